// File: rtl/shift_pkg.sv
// ============================================================================
// Module      : shift_pkg
// Description : Shared constants and request type for the shift pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_pkg;

   localparam int WIDTH   = 16;
   localparam int SHAMT_W = 4;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   typedef struct packed {
      logic [WIDTH-1:0]   a;
      logic               sel;
      logic [SHAMT_W-1:0] s;
   } shift_req_t;

endpackage

`default_nettype wire

// File: rtl/shifter_core.sv
// ============================================================================
// Module      : shifter_core
// Description : Combinational 16-bit logical left/right barrel shifter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shifter_core
   import shift_pkg::*;
(
   input  logic [WIDTH-1:0]   a,
   input  logic               sel,
   input  logic [SHAMT_W-1:0] s,
   output logic [WIDTH-1:0]   y
);

   logic [WIDTH-1:0] w_a_rev;
   logic [WIDTH-1:0] w_y_rev;
   logic [WIDTH-1:0] w_stage [SHAMT_W+1];

   // Right shifts reuse the left-shift network on a bit-reversed operand.
   always_comb begin
      w_a_rev = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_a_rev[i] = a[WIDTH-1-i];
      end
   end

   assign w_stage[0] = (sel == DIR_RIGHT) ? w_a_rev : a;

   for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
      assign w_stage[k+1] = s[k] ? (w_stage[k] << (1 << k)) : w_stage[k];
   end

   always_comb begin
      w_y_rev = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_y_rev[i] = w_stage[SHAMT_W][WIDTH-1-i];
      end
   end

   assign y = (sel == DIR_RIGHT) ? w_y_rev : w_stage[SHAMT_W];

endmodule

`default_nettype wire

// File: rtl/shift_pipe_ctrl.sv
// ============================================================================
// Module      : shift_pipe_ctrl
// Description : Two-stage valid/ready pipeline around the barrel shifter,
//               with completed-operation counter and zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_pipe_ctrl #(
   parameter int WIDTH   = 16,
   parameter int SHAMT_W = 4,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic               in_sel,
   input  logic [SHAMT_W-1:0] in_s,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_y,
   output logic               out_zero,
   output logic [CNT_W-1:0]   done_cnt,
   output logic               busy
);

   import shift_pkg::*;

   shift_req_t       r_s1_req;
   logic             r_s1_valid;
   logic [WIDTH-1:0] r_out_y;
   logic             r_out_zero;
   logic             r_out_valid;
   logic [CNT_W-1:0] r_done_cnt;

   logic             w_handoff;
   logic             w_s1_load;
   logic             w_s2_load;
   logic [WIDTH-1:0] w_shift_y;

   assign w_handoff = r_out_valid && out_ready;
   assign in_ready  = !flush && (!r_s1_valid || !r_out_valid || out_ready);
   assign w_s1_load = in_valid && in_ready;
   assign w_s2_load = r_s1_valid && (!r_out_valid || out_ready);

   shifter_core u_core (
      .a   (r_s1_req.a),
      .sel (r_s1_req.sel),
      .s   (r_s1_req.s),
      .y   (w_shift_y)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_req   <= '0;
      end else begin
         if (flush) begin
            r_s1_valid <= 1'b0;
         end else if (w_s1_load) begin
            r_s1_valid <= 1'b1;
         end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
         end
         if (w_s1_load) begin
            r_s1_req <= '{a: in_a, sel: in_sel, s: in_s};
         end
      end
   end

   // Result data may load during a flush; out_valid masks it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_y     <= '0;
         r_out_zero  <= 1'b0;
      end else begin
         if (flush) begin
            r_out_valid <= 1'b0;
         end else if (w_s2_load) begin
            r_out_valid <= 1'b1;
         end else if (w_handoff) begin
            r_out_valid <= 1'b0;
         end
         if (w_s2_load) begin
            r_out_y    <= w_shift_y;
            r_out_zero <= (w_shift_y == '0);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done_cnt <= '0;
      end else if (w_handoff) begin
         r_done_cnt <= r_done_cnt + 1'b1;
      end
   end

   assign out_valid = r_out_valid;
   assign out_y     = r_out_y;
   assign out_zero  = r_out_zero && r_out_valid;
   assign done_cnt  = r_done_cnt;
   assign busy      = r_s1_valid || r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_shift_pipe_ctrl.sv
// ============================================================================
// Module      : tb_shift_pipe_ctrl
// Description : Scoreboard testbench for shift_pipe_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_a = '0;
   logic        in_sel = 1'b0;
   logic [3:0]  in_s = '0;
   logic        out_ready = 1'b0;
   logic        in_ready;
   logic        out_valid;
   logic [15:0] out_y;
   logic        out_zero;
   logic [15:0] done_cnt;
   logic        busy;

   shift_pipe_ctrl #(.WIDTH(16), .SHAMT_W(4), .CNT_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_sel    (in_sel),
      .in_s      (in_s),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .out_zero  (out_zero),
      .done_cnt  (done_cnt),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] y;
      int          acc;
   } exp_t;

   exp_t        sb[$];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   logic [15:0] exp_cnt = '0;
   logic        hold_prev = 1'b0;
   logic [15:0] y_prev = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference: plain integer arithmetic on the operand.
   function automatic logic [15:0] ref_shift(input logic [15:0] a, input logic sel, input logic [3:0] s);
      int unsigned v;
      int unsigned p;
      v = a;
      p = 1 << s;
      if (sel) v = v / p;
      else     v = (v * p) % 65536;
      return v[15:0];
   endfunction

   // Monitor: samples 2 time units before each rising edge.
   always begin
      logic exp_valid;
      @(negedge clk);
      #3;
      if (!rst_n) begin
         hold_prev = 1'b0;
      end else begin
         exp_valid = (sb.size() > 0) && (cyc >= sb[0].acc + 2);
         chk("out_valid", out_valid, exp_valid);
         chk("in_ready", in_ready, !flush && (sb.size() < 2 || out_ready));
         chk("busy", busy, sb.size() > 0);
         chk("done_cnt", done_cnt, exp_cnt);
         if (hold_prev && out_valid) chk("out_y_hold", out_y, y_prev);
         if (out_valid && sb.size() > 0) begin
            chk("out_y", out_y, sb[0].y);
            chk("out_zero", out_zero, sb[0].y == 16'h0000);
         end
         hold_prev = out_valid && !out_ready;
         y_prev    = out_y;
         if (out_valid && out_ready) begin
            if (sb.size() > 0) void'(sb.pop_front());
            exp_cnt = exp_cnt + 16'd1;
         end
      end
   end

   // One cycle of stimulus; pushes the expected result on accept.
   task automatic drive(input logic v, input logic [15:0] a, input logic sel,
                        input logic [3:0] s, input logic ordy, input logic fl);
      exp_t e;
      @(negedge clk);
      in_valid  = v;
      in_a      = a;
      in_sel    = sel;
      in_s      = s;
      out_ready = ordy;
      flush     = fl;
      #4;
      if (rst_n && v && in_ready) begin
         e.y   = ref_shift(a, sel, s);
         e.acc = cyc;
         sb.push_back(e);
      end
      if (rst_n && fl) sb.delete();
   endtask

   task automatic idle(input logic ordy);
      drive(1'b0, 16'h0000, 1'b0, 4'd0, ordy, 1'b0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 50) begin
         idle(1'b1);
         n++;
      end
      if (sb.size() > 0) chk("drain_timeout", sb.size(), 0);
      idle(1'b1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      sb.delete();
      exp_cnt = '0;
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_y", out_y, 16'h0000);
      chk("rst_out_zero", out_zero, 1'b0);
      chk("rst_done_cnt", done_cnt, 16'h0000);
      chk("rst_busy", busy, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b1;
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   logic [15:0] kat_a   [6] = '{16'h8001, 16'h8000, 16'h1234, 16'h1234, 16'h00F0, 16'h00F0};
   logic        kat_sel [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   logic [3:0]  kat_s   [6] = '{4'd1, 4'd15, 4'd0, 4'd0, 4'd12, 4'd4};
   logic [15:0] kat_y   [6] = '{16'h0002, 16'h0001, 16'h1234, 16'h1234, 16'h0000, 16'h000F};

   initial begin
      logic [15:0] base;
      logic        rdy [3];

      #1;
      chk("init_out_valid", out_valid, 1'b0);
      chk("init_out_y", out_y, 16'h0000);
      chk("init_out_zero", out_zero, 1'b0);
      chk("init_done_cnt", done_cnt, 16'h0000);
      chk("init_busy", busy, 1'b0);
      chk("init_in_ready", in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      // Known-answer vectors, each isolated and held one cycle at the output.
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, kat_a[i], kat_sel[i], kat_s[i], 1'b0, 1'b0);
         idle(1'b0);
         idle(1'b0);
         chk("kat_valid", out_valid, 1'b1);
         chk("kat_y", out_y, kat_y[i]);
         chk("kat_zero", out_zero, kat_y[i] == 16'h0000);
         idle(1'b1);
         idle(1'b1);
         chk("kat_done_cnt", done_cnt, i + 1);
      end

      // Streaming: 8 back-to-back requests at full throughput.
      base = done_cnt;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 16'($urandom), 1'($urandom), 4'($urandom), 1'b1, 1'b0);
         chk("stream_in_ready", in_ready, 1'b1);
      end
      drain();
      chk("stream_done_cnt", done_cnt, base + 16'd8);

      // Backpressure: third request must be refused while two are held.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 16'h1111 * (i + 1), 1'b0, 4'(i), 1'b0, 1'b0);
         rdy[i] = in_ready;
      end
      chk("bp_ready0", rdy[0], 1'b1);
      chk("bp_ready1", rdy[1], 1'b1);
      chk("bp_ready2", rdy[2], 1'b0);
      repeat (3) drive(1'b1, 16'h3333, 1'b0, 4'd2, 1'b0, 1'b0);
      drive(1'b1, 16'h3333, 1'b0, 4'd2, 1'b1, 1'b0);
      chk("bp_release_ready", in_ready, 1'b1);
      drain();

      // Flush with two requests in flight and a new request offered.
      base = done_cnt;
      drive(1'b1, 16'hAAAA, 1'b1, 4'd3, 1'b0, 1'b0);
      drive(1'b1, 16'h5555, 1'b0, 4'd5, 1'b0, 1'b0);
      drive(1'b1, 16'hFFFF, 1'b0, 4'd1, 1'b0, 1'b1);
      chk("flush_in_ready", in_ready, 1'b0);
      idle(1'b0);
      chk("flush_out_valid", out_valid, 1'b0);
      chk("flush_busy", busy, 1'b0);
      chk("flush_done_cnt", done_cnt, base);

      // Asynchronous reset in the middle of a stream.
      for (int i = 0; i < 4; i++)
         drive(1'b1, 16'($urandom), 1'($urandom), 4'($urandom), 1'b1, 1'b0);
      do_reset();

      // Randomized traffic with occasional backpressure and flush.
      for (int i = 0; i < 3000; i++)
         drive(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom), 4'($urandom),
               $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
      drain();

      // Counter wrap.
      do_reset();
      for (int i = 0; i < 65535; i++)
         drive(1'b1, 16'($urandom), 1'($urandom), 4'($urandom), 1'b1, 1'b0);
      drain();
      chk("wrap_pre", done_cnt, 16'hFFFF);
      drive(1'b1, 16'h0F0F, 1'b1, 4'd4, 1'b1, 1'b0);
      drain();
      chk("wrap_post", done_cnt, 16'h0000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/shift_pipe_ctrl.md
# shift_pipe_ctrl

Pipelined, handshaked front-end for the 16-bit logical barrel shifter datapath. It accepts shift requests (operand, direction, amount) on a valid/ready interface, registers them, performs the shift, and presents registered results downstream with backpressure. It also maintains a completed-operation counter and a zero flag. It sits between the instruction/ALU issue logic and the writeback path, turning the purely combinational shifter into a 2-cycle, full-throughput pipeline stage.

## Interface
Parameters:
- WIDTH, 16, operand/result width; fixed at 16 for this revision.
- SHAMT_W, 4, shift-amount width, equal to log2(WIDTH).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low. The design uses one clock; reset is asynchronous and active-low.
- flush  input  1  synchronous pipeline flush.
- in_valid  input  1  request present.
- in_ready  output  1  request accepted when in_valid && in_ready.
- in_a  input  WIDTH  operand.
- in_sel  input  1  direction: 0 = left, 1 = right (logical, zero fill).
- in_s  input  SHAMT_W  shift amount, 0..15.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- out_y  output  WIDTH  shifted result.
- out_zero  output  1  out_y == 0, qualified by out_valid.
- done_cnt  output  CNT_W  number of results handed off since reset.
- busy  output  1  s1_valid || out_valid.

## Operation
- Stage 1 (request register): captures {in_a, in_sel, in_s} on accept and sets s1_valid.
- Stage 2 (result register): captures shifter_core(s1 fields), computes zero = (shift result == 0), and sets out_valid.
- Advance rule: stage 2 loads when s1_valid && (!out_valid || out_ready). Stage 1 loads when in_valid && in_ready.
- in_ready = !flush && (!s1_valid || !out_valid || out_ready). This is combinational from out_ready and flush.
- Shift semantics:
  - Left: out_y = (a << s) truncated to WIDTH.
  - Right: out_y = a >> s.
  - s = 0 passes the operand unchanged in both directions.
- done_cnt increments by 1 on each out_valid && out_ready. It wraps from 2^CNT_W−1 to 0.
- flush:
  - On the next edge, s1_valid and out_valid clear. Data registers are don't-care.
  - done_cnt is unaffected by flush, but a handoff completing in the flush cycle is still counted.
  - A request presented during flush is not accepted (in_ready = 0).
- Simultaneous events:
  - Accept into stage 1 while stage 1 drains into stage 2 in the same cycle: both occur, and the new request replaces the old one in stage 1.
  - Output handoff while stage 2 reloads in the same cycle: both occur, with no bubble.
- Ordering: results leave in request order. No request is dropped or duplicated except by flush or reset.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_y = 0, out_zero = 0, done_cnt = 0, busy = 0. Internal s1_valid = 0 and stage registers = 0.
- Latency: a request accepted at edge N has out_valid high after edge N+1, provided stage 2 was free or draining.
- Throughput: 1 result per cycle when out_ready stays high.
- Storage: 2 entries in total. With out_ready low, at most two requests are held; in_ready then drops in the cycle both are valid.
- out_y and out_zero hold stable while out_valid && !out_ready.
- Reset asserted mid-operation: all valids clear immediately (asynchronously). Outputs take their reset values, and in-flight requests are lost.

## Structure
- Shared package shift_pkg holds:
  - constants WIDTH = 16 and SHAMT_W = 4;
  - DIR_LEFT = 1'b0 and DIR_RIGHT = 1'b1;
  - a packed struct shift_req_t {a, sel, s}.
- One sub-module, shifter_core: a combinational 16-bit logical left/right shifter with inputs a, sel, s and output y. It is instantiated once between stage 1 and stage 2.
- The top level contains only the two stage registers, handshake logic, counter and flag.

## Test plan
- Basic shifts:
  - a = 0x8001, sel = 0, s = 1 → out_y = 0x0002 two edges after accept, done_cnt = 1.
  - a = 0x8000, sel = 1, s = 15 → out_y = 0x0001.
  - a = 0x1234, s = 0 with either sel → out_y = 0x1234.
- Zero flag: a = 0x00F0, sel = 0, s = 12 → out_y = 0x0000 and out_zero = 1. Then a = 0x00F0, sel = 1, s = 4 → out_y = 0x000F and out_zero = 0.
- Streaming: 8 back-to-back requests with out_ready held at 1 → 8 consecutive results in order, in_ready never low, done_cnt = 8.
- Backpressure: hold out_ready = 0 and offer 3 requests → first two accepted, in_ready = 0 on the third. out_y is held stable. Release out_ready → all three emerge in order with no loss.
- Flush and reset: with two requests in flight, assert flush together with a new in_valid → next cycle out_valid = 0, busy = 0, nothing accepted, done_cnt unchanged. Then assert rst_n = 0 asynchronously mid-stream → all outputs reach reset values before the next edge.
- Counter wrap: preload traffic until done_cnt = 0xFFFF, then complete one handoff → done_cnt = 0x0000.
